// File: rtl/boot_seq_if.sv
// Pad-side signal bundle of the boot sequencer: pad/core controls in, core gating out.
interface boot_seq_if;
  logic       fetch_enable_i;
  logic       spi_cs_ni;
  logic       testmode_i;
  logic       eoc_i;
  logic       restart_i;
  logic       core_rst_no;
  logic       fetch_enable_o;
  logic       eoc_o;
  logic [2:0] state_o;

  modport master (
    output fetch_enable_i, spi_cs_ni, testmode_i, eoc_i, restart_i,
    input  core_rst_no, fetch_enable_o, eoc_o, state_o
  );

  modport slave (
    input  fetch_enable_i, spi_cs_ni, testmode_i, eoc_i, restart_i,
    output core_rst_no, fetch_enable_o, eoc_o, state_o
  );
endinterface

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: holds the core in reset, then gates fetch-enable until the pad is
// high and SPI chip-select has been idle for a settle window; latches end-of-computation.
module boot_seq_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_WIDTH     = 8
) (
  input logic       clk,
  input logic       rst_n,
  boot_seq_if.slave bus
);

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

  logic fe_p0, fe_s;
  logic cs_p0, cs_s;

  logic       core_rst_n_q;
  logic       fetch_en_q;
  logic       eoc_q;
  logic [2:0] state_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Pad synchronisers: chip-select idles high so it resets to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_p0 <= 1'b0;
      fe_s  <= 1'b0;
      cs_p0 <= 1'b1;
      cs_s  <= 1'b1;
    end else begin
      fe_p0 <= bus.fetch_enable_i;
      fe_s  <= fe_p0;
      cs_p0 <= bus.spi_cs_ni;
      cs_s  <= cs_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    if (bus.restart_i) begin
      state_nxt = HOLD;
    end else if (bus.eoc_i && state == RUN) begin
      state_nxt = DONE;
    end else begin
      case (state)
        HOLD: begin
          if (bus.testmode_i || cnt == RST_LAST) begin
            state_nxt = LOAD;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        LOAD: begin
          if (fe_s && cs_s) begin
            state_nxt = bus.testmode_i ? RUN : SETTLE;
          end
        end
        SETTLE: begin
          if (!fe_s || !cs_s) begin
            state_nxt = LOAD;
          end else if (cnt == SETTLE_LAST) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        // Dropping the pad only gates fetch; the core stays out of reset
        RUN: begin
          if (!fe_s) begin
            state_nxt = LOAD;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = HOLD;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HOLD;
      cnt          <= '0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      eoc_q        <= 1'b0;
      state_q      <= 3'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      core_rst_n_q <= (state_nxt != HOLD);
      fetch_en_q   <= (state_nxt == RUN);
      eoc_q        <= (state_nxt == DONE);
      state_q      <= state_nxt;
    end
  end

  assign bus.core_rst_no    = core_rst_n_q;
  assign bus.fetch_enable_o = fetch_en_q;
  assign bus.eoc_o          = eoc_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl with default parameters (16 hold, 8 settle).
module tb_boot_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  boot_seq_if bus();

  boot_seq_ctrl #(
    .RST_CYCLES   (16),
    .SETTLE_CYCLES(8),
    .CNT_WIDTH    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic tm, input logic fe);
    rst_n = 1'b0;
    bus.testmode_i     = tm;
    bus.fetch_enable_i = fe;
    bus.spi_cs_ni      = 1'b1;
    bus.eoc_i          = 1'b0;
    bus.restart_i      = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.testmode_i     = 1'b0;
    bus.fetch_enable_i = 1'b0;
    bus.spi_cs_ni      = 1'b1;
    bus.eoc_i          = 1'b0;
    bus.restart_i      = 1'b0;
    step(3);
    checks++;
    if (bus.core_rst_no !== 1'b0) begin
      errors++; $display("FAIL reset_core_rst_no got %b exp 0", bus.core_rst_no);
    end
    checks++;
    if (bus.fetch_enable_o !== 1'b0) begin
      errors++; $display("FAIL reset_fetch_enable got %b exp 0", bus.fetch_enable_o);
    end
    checks++;
    if (bus.eoc_o !== 1'b0) begin
      errors++; $display("FAIL reset_eoc got %b exp 0", bus.eoc_o);
    end
    checks++;
    if (bus.state_o !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", bus.state_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_hold_release();
    step(15);
    checks++;
    if (bus.core_rst_no !== 1'b0 || bus.state_o !== 3'd0) begin
      errors++; $display("FAIL hold_edge15 got rst_no=%b state=%0d exp rst_no=0 state=0", bus.core_rst_no, bus.state_o);
    end
    step(1);
    checks++;
    if (bus.core_rst_no !== 1'b1 || bus.state_o !== 3'd1) begin
      errors++; $display("FAIL hold_edge16 got rst_no=%b state=%0d exp rst_no=1 state=1", bus.core_rst_no, bus.state_o);
    end
    bus.eoc_i = 1'b1;
    step(1);
    bus.eoc_i = 1'b0;
    step(20);
    checks++;
    if (bus.fetch_enable_o !== 1'b0 || bus.state_o !== 3'd1 || bus.eoc_o !== 1'b0) begin
      errors++; $display("FAIL load_idle got fe_o=%b state=%0d eoc=%b exp fe_o=0 state=1 eoc=0", bus.fetch_enable_o, bus.state_o, bus.eoc_o);
    end
  endtask

  task automatic test_load_to_run();
    bus.fetch_enable_i = 1'b1;
    step(10);
    checks++;
    if (bus.fetch_enable_o !== 1'b0 || bus.state_o !== 3'd2) begin
      errors++; $display("FAIL settle_edge10 got fe_o=%b state=%0d exp fe_o=0 state=2", bus.fetch_enable_o, bus.state_o);
    end
    step(1);
    checks++;
    if (bus.fetch_enable_o !== 1'b1 || bus.state_o !== 3'd3) begin
      errors++; $display("FAIL run_edge11 got fe_o=%b state=%0d exp fe_o=1 state=3", bus.fetch_enable_o, bus.state_o);
    end
  endtask

  task automatic test_run_fe_drop();
    bus.fetch_enable_i = 1'b0;
    step(2);
    checks++;
    if (bus.state_o !== 3'd3) begin
      errors++; $display("FAIL fe_drop_edge2 got state=%0d exp 3", bus.state_o);
    end
    step(1);
    checks++;
    if (bus.state_o !== 3'd1 || bus.core_rst_no !== 1'b1 || bus.fetch_enable_o !== 1'b0) begin
      errors++; $display("FAIL fe_drop_edge3 got state=%0d rst_no=%b fe_o=%b exp state=1 rst_no=1 fe_o=0", bus.state_o, bus.core_rst_no, bus.fetch_enable_o);
    end
  endtask

  task automatic test_settle_cs_glitch();
    bus.fetch_enable_i = 1'b1;
    step(3);
    checks++;
    if (bus.state_o !== 3'd2) begin
      errors++; $display("FAIL glitch_enter_settle got state=%0d exp 2", bus.state_o);
    end
    step(4);
    bus.spi_cs_ni = 1'b0;
    step(3);
    checks++;
    if (bus.state_o !== 3'd1) begin
      errors++; $display("FAIL glitch_back_to_load got state=%0d exp 1", bus.state_o);
    end
    bus.spi_cs_ni = 1'b1;
    step(10);
    checks++;
    if (bus.fetch_enable_o !== 1'b0 || bus.state_o !== 3'd2) begin
      errors++; $display("FAIL glitch_edge10 got fe_o=%b state=%0d exp fe_o=0 state=2", bus.fetch_enable_o, bus.state_o);
    end
    step(1);
    checks++;
    if (bus.fetch_enable_o !== 1'b1 || bus.state_o !== 3'd3) begin
      errors++; $display("FAIL glitch_edge11 got fe_o=%b state=%0d exp fe_o=1 state=3", bus.fetch_enable_o, bus.state_o);
    end
  endtask

  task automatic test_eoc();
    bus.eoc_i = 1'b1;
    step(1);
    bus.eoc_i = 1'b0;
    checks++;
    if (bus.state_o !== 3'd4 || bus.eoc_o !== 1'b1 || bus.fetch_enable_o !== 1'b0) begin
      errors++; $display("FAIL eoc_enter_done got state=%0d eoc=%b fe_o=%b exp state=4 eoc=1 fe_o=0", bus.state_o, bus.eoc_o, bus.fetch_enable_o);
    end
    step(2);
    bus.eoc_i = 1'b1;
    step(1);
    bus.eoc_i = 1'b0;
    step(1);
    checks++;
    if (bus.state_o !== 3'd4 || bus.eoc_o !== 1'b1 || bus.core_rst_no !== 1'b1) begin
      errors++; $display("FAIL done_sticky got state=%0d eoc=%b rst_no=%b exp state=4 eoc=1 rst_no=1", bus.state_o, bus.eoc_o, bus.core_rst_no);
    end
    bus.restart_i = 1'b1;
    step(1);
    bus.restart_i = 1'b0;
    checks++;
    if (bus.state_o !== 3'd0 || bus.core_rst_no !== 1'b0 || bus.eoc_o !== 1'b0) begin
      errors++; $display("FAIL restart got state=%0d rst_no=%b eoc=%b exp state=0 rst_no=0 eoc=0", bus.state_o, bus.core_rst_no, bus.eoc_o);
    end
    step(15);
    checks++;
    if (bus.state_o !== 3'd0) begin
      errors++; $display("FAIL rehold_edge15 got state=%0d exp 0", bus.state_o);
    end
    step(1);
    checks++;
    if (bus.state_o !== 3'd1 || bus.core_rst_no !== 1'b1) begin
      errors++; $display("FAIL rehold_edge16 got state=%0d rst_no=%b exp state=1 rst_no=1", bus.state_o, bus.core_rst_no);
    end
    step(8);
    checks++;
    if (bus.state_o !== 3'd2) begin
      errors++; $display("FAIL reseq_settle got state=%0d exp 2", bus.state_o);
    end
    step(1);
    checks++;
    if (bus.state_o !== 3'd3 || bus.fetch_enable_o !== 1'b1) begin
      errors++; $display("FAIL reseq_run got state=%0d fe_o=%b exp state=3 fe_o=1", bus.state_o, bus.fetch_enable_o);
    end
  endtask

  task automatic test_eoc_restart_same();
    bus.eoc_i     = 1'b1;
    bus.restart_i = 1'b1;
    step(1);
    bus.eoc_i     = 1'b0;
    bus.restart_i = 1'b0;
    checks++;
    if (bus.state_o !== 3'd0 || bus.eoc_o !== 1'b0 || bus.core_rst_no !== 1'b0) begin
      errors++; $display("FAIL eoc_vs_restart got state=%0d eoc=%b rst_no=%b exp state=0 eoc=0 rst_no=0", bus.state_o, bus.eoc_o, bus.core_rst_no);
    end
  endtask

  task automatic test_testmode();
    do_reset(1'b1, 1'b1);
    step(1);
    checks++;
    if (bus.core_rst_no !== 1'b1 || bus.state_o !== 3'd1) begin
      errors++; $display("FAIL tm_hold_exit got rst_no=%b state=%0d exp rst_no=1 state=1", bus.core_rst_no, bus.state_o);
    end
    step(1);
    checks++;
    if (bus.fetch_enable_o !== 1'b0) begin
      errors++; $display("FAIL tm_edge2 got fe_o=%b exp 0", bus.fetch_enable_o);
    end
    step(1);
    checks++;
    if (bus.fetch_enable_o !== 1'b1 || bus.state_o !== 3'd3) begin
      errors++; $display("FAIL tm_run got fe_o=%b state=%0d exp fe_o=1 state=3", bus.fetch_enable_o, bus.state_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.core_rst_no !== 1'b0 || bus.fetch_enable_o !== 1'b0 || bus.eoc_o !== 1'b0 || bus.state_o !== 3'd0) begin
      errors++; $display("FAIL async_reset got rst_no=%b fe_o=%b eoc=%b state=%0d exp all 0", bus.core_rst_no, bus.fetch_enable_o, bus.eoc_o, bus.state_o);
    end
    bus.testmode_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hold_release();
    test_load_to_run();
    test_run_fe_drop();
    test_settle_cs_glitch();
    test_eoc();
    test_eoc_restart_same();
    test_testmode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
